// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: tracked stage entry and forward selects.
package hazard_pkg;

    localparam int MAX_AW = 8;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic              valid;
        logic              regwr;
        logic              load;
        logic [MAX_AW-1:0] rd;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    function automatic stage_t mk_stage(
        input logic              regwr,
        input logic              load,
        input logic [MAX_AW-1:0] rd
    );
        stage_t s;
        s.valid = 1'b1;
        s.regwr = regwr;
        s.load  = load;
        s.rd    = rd;
        return s;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-producer lookup for one source register across the tracked stages.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int SW     = $clog2(DEPTH + 1)
) (
    input  stage_t [DEPTH:1]    entries,
    input  logic   [REG_AW-1:0] src,
    output logic                hit,
    output logic   [SW-1:0]     idx,
    output logic                is_load
);

    logic [MAX_AW-1:0] src_x;

    assign src_x = MAX_AW'(src);

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        is_load = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (entries[k].valid && entries[k].regwr &&
                entries[k].rd == src_x && src_x != '0) begin
                hit     = 1'b1;
                idx     = SW'(k);
                is_load = entries[k].load;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use stall and EX forward-select generation; FWD_BRANCH_EN adds
// ID-stage branch-compare forwarding.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 3,
    localparam int SW        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwr,
    input  logic              id_load,
    input  logic              flush,
    output logic              stall,
    output logic [SW-1:0]     ex_fwd_rs,
    output logic [SW-1:0]     ex_fwd_rt,
    output logic [15:0]       stall_count
`ifdef FWD_BRANCH_EN
    ,
    input  logic              id_branch,
    output logic [SW-1:0]     id_cmp_rs,
    output logic [SW-1:0]     id_cmp_rt
`endif
);

    stage_t [DEPTH:1] entries;

    logic          hit_rs, hit_rt;
    logic          ld_rs, ld_rt;
    logic [SW-1:0] j_rs, j_rt;
    logic          use_hit_rs, use_hit_rt;
    logic          lu_rs, lu_rt;
    logic          br_haz;
    logic          take;
    logic [SW-1:0] fwd_rs_next, fwd_rt_next;

    hazard_match #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .SW     (SW)
    ) u_match_rs (
        .entries (entries),
        .src     (id_rs),
        .hit     (hit_rs),
        .idx     (j_rs),
        .is_load (ld_rs)
    );

    hazard_match #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .SW     (SW)
    ) u_match_rt (
        .entries (entries),
        .src     (id_rt),
        .hit     (hit_rt),
        .idx     (j_rt),
        .is_load (ld_rt)
    );

    assign use_hit_rs = id_use_rs & hit_rs;
    assign use_hit_rt = id_use_rt & hit_rt;

    assign lu_rs = use_hit_rs & ld_rs &
                   ((int'(j_rs) + 1) < LOAD_READY);
    assign lu_rt = use_hit_rt & ld_rt &
                   ((int'(j_rt) + 1) < LOAD_READY);

`ifdef FWD_BRANCH_EN
    logic br_rs, br_rt;

    assign br_rs = use_hit_rs &
                   ((int'(j_rs) == 1) |
                    (ld_rs & (int'(j_rs) < LOAD_READY)));
    assign br_rt = use_hit_rt &
                   ((int'(j_rt) == 1) |
                    (ld_rt & (int'(j_rt) < LOAD_READY)));
    assign br_haz = id_branch & (br_rs | br_rt);

    assign id_cmp_rs = (use_hit_rs & ~ld_rs & (int'(j_rs) >= 2))
                       ? j_rs : SW'(FWD_RF);
    assign id_cmp_rt = (use_hit_rt & ~ld_rt & (int'(j_rt) >= 2))
                       ? j_rt : SW'(FWD_RF);
`else
    assign br_haz = 1'b0;
`endif

    assign stall = ~reset & id_valid & ~flush &
                   (lu_rs | lu_rt | br_haz);

    assign take = id_valid & ~stall & ~flush;

    // Producer moves one stage along with the consumer; leaving the
    // window means it has committed and the register file has it.
    assign fwd_rs_next = (use_hit_rs && (int'(j_rs) + 1) <= DEPTH)
                         ? SW'(int'(j_rs) + 1) : SW'(FWD_RF);
    assign fwd_rt_next = (use_hit_rt && (int'(j_rt) + 1) <= DEPTH)
                         ? SW'(int'(j_rt) + 1) : SW'(FWD_RF);

    always_ff @(posedge clk) begin
        if (reset) begin
            entries     <= '0;
            ex_fwd_rs   <= SW'(FWD_RF);
            ex_fwd_rt   <= SW'(FWD_RF);
            stall_count <= '0;
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                entries[k] <= entries[k-1];
            end
            if (take) begin
                entries[1] <= mk_stage(id_regwr, id_load,
                                       MAX_AW'(id_rd));
                ex_fwd_rs  <= fwd_rs_next;
                ex_fwd_rt  <= fwd_rt_next;
            end else begin
                entries[1] <= BUBBLE;
                ex_fwd_rs  <= SW'(FWD_RF);
                ex_fwd_rt  <= SW'(FWD_RF);
            end
            if (stall && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against a history-queue model.
module tb_hazard_scoreboard;

    localparam int AW    = 5;
    localparam int DEPTH = 3;
    localparam int LR    = 3;
    localparam int SW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          id_valid;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          id_use_rs, id_use_rt;
    logic          id_regwr, id_load;
    logic          flush;
    logic          stall;
    logic [SW-1:0] ex_fwd_rs, ex_fwd_rt;
    logic [15:0]   stall_count;
`ifdef FWD_BRANCH_EN
    logic          id_branch;
    logic [SW-1:0] id_cmp_rs, id_cmp_rt;
`endif

    hazard_scoreboard #(
        .REG_AW     (AW),
        .DEPTH      (DEPTH),
        .LOAD_READY (LR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_rd       (id_rd),
        .id_regwr    (id_regwr),
        .id_load     (id_load),
        .flush       (flush),
        .stall       (stall),
        .ex_fwd_rs   (ex_fwd_rs),
        .ex_fwd_rt   (ex_fwd_rt),
        .stall_count (stall_count)
`ifdef FWD_BRANCH_EN
        ,
        .id_branch   (id_branch),
        .id_cmp_rs   (id_cmp_rs),
        .id_cmp_rt   (id_cmp_rt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit v;
        bit wr;
        bit ld;
        int rd;
    } ent_t;

    ent_t hist[$];
    int   errors = 0;
    int   checks = 0;
    int   m_fwd_rs, m_fwd_rt, m_cnt;
    int   obs_stall;

    task automatic check(input string tag, input logic [31:0] obs,
                         input int exp);
        checks++;
        if (obs !== 32'(exp)) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        ent_t b;
        b = '{v: 0, wr: 0, ld: 0, rd: 0};
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back(b);
        m_fwd_rs = 0;
        m_fwd_rt = 0;
        m_cnt    = 0;
    endfunction

    // Distance (1 = EX) to the youngest writer of src, 0 if none.
    function automatic int find(input bit used, input int src);
        if (!used || src == 0) return 0;
        for (int j = 1; j <= DEPTH; j++) begin
            if (hist[j-1].v && hist[j-1].wr && hist[j-1].rd == src)
                return j;
        end
        return 0;
    endfunction

    function automatic bit is_ld(input int j);
        return j != 0 && hist[j-1].ld;
    endfunction

    function automatic int sel(input int j);
        return (j != 0 && j + 1 <= DEPTH) ? j + 1 : 0;
    endfunction

    task automatic step(input bit v, input int rs, input int rt,
                        input bit urs, input bit urt, input int rd,
                        input bit wr, input bit ld, input bit fl,
                        input bit rst, input bit br = 0);
        int  jr, jt;
        bit  es, take;
        ent_t e;
        id_valid  = v;
        id_rs     = rs[AW-1:0];
        id_rt     = rt[AW-1:0];
        id_use_rs = urs;
        id_use_rt = urt;
        id_rd     = rd[AW-1:0];
        id_regwr  = wr;
        id_load   = ld;
        flush     = fl;
        reset     = rst;
`ifdef FWD_BRANCH_EN
        id_branch = br;
`endif
        #1;
        jr = find(urs, rs);
        jt = find(urt, rt);
        es = (is_ld(jr) && jr + 1 < LR) || (is_ld(jt) && jt + 1 < LR);
`ifdef FWD_BRANCH_EN
        if (br && (jr == 1 || jt == 1 ||
                   (is_ld(jr) && jr < LR) || (is_ld(jt) && jt < LR)))
            es = 1;
        if (!rst) begin
            check("cmp_rs", id_cmp_rs,
                  (jr >= 2 && !is_ld(jr)) ? jr : 0);
            check("cmp_rt", id_cmp_rt,
                  (jt >= 2 && !is_ld(jt)) ? jt : 0);
        end
`else
        if (br) es = es;
`endif
        es = es && !rst && v && !fl;
        check("stall", stall, es);
        obs_stall = stall;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (es && m_cnt < 65535) m_cnt++;
            take = v && !es && !fl;
            e = '{v: take, wr: wr && take, ld: ld && take,
                  rd: take ? rd : 0};
            m_fwd_rs = take ? sel(jr) : 0;
            m_fwd_rt = take ? sel(jt) : 0;
            hist.push_front(e);
            void'(hist.pop_back());
        end
        #1;
        check("ex_fwd_rs", ex_fwd_rs, m_fwd_rs);
        check("ex_fwd_rt", ex_fwd_rt, m_fwd_rt);
        check("stall_count", stall_count, m_cnt);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        model_clear();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        do_reset();
        check("rst_stall", stall, 0);
        check("rst_fwd_rs", ex_fwd_rs, 0);
        check("rst_cnt", stall_count, 0);

        // add r3 ; add r4,r3
        step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
        step(1, 3, 0, 1, 0, 4, 1, 0, 0, 0);
        check("add_add_stall", obs_stall, 0);
        check("add_add_fwd", ex_fwd_rs, 2);

        // lw r5 ; sub r6,r0,r5
        do_reset();
        step(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
        step(1, 0, 5, 1, 1, 6, 1, 0, 0, 0);
        check("lu_stall", obs_stall, 1);
        check("lu_bubble_fwd", ex_fwd_rt, 0);
        step(1, 0, 5, 1, 1, 6, 1, 0, 0, 0);
        check("lu_release", obs_stall, 0);
        check("lu_fwd_rt", ex_fwd_rt, 3);
        check("lu_cnt", stall_count, 1);

        // two writers of r7; younger wins
        step(1, 1, 1, 1, 1, 7, 1, 0, 0, 0);
        step(1, 2, 2, 1, 1, 7, 1, 0, 0, 0);
        step(1, 7, 0, 1, 0, 8, 1, 0, 0, 0);
        check("young_fwd", ex_fwd_rs, 2);

        // r0 writes and unused source
        step(1, 1, 1, 1, 1, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 1, 9, 1, 0, 0, 0);
        check("r0_stall", obs_stall, 0);
        check("r0_fwd", ex_fwd_rs, 0);
        step(1, 1, 1, 1, 1, 10, 1, 1, 0, 0);
        step(1, 10, 1, 0, 1, 11, 1, 0, 0, 0);
        check("unused_stall", obs_stall, 0);
        check("unused_fwd", ex_fwd_rs, 0);

        // flush during load-use, reset mid-stall
        do_reset();
        step(1, 1, 1, 1, 1, 5, 1, 1, 0, 0);
        step(1, 5, 0, 1, 0, 6, 1, 0, 1, 0);
        check("flush_stall", obs_stall, 0);
        check("flush_fwd", ex_fwd_rs, 0);
        step(1, 1, 1, 1, 1, 5, 1, 1, 0, 0);
        step(1, 5, 0, 1, 0, 6, 1, 0, 0, 0);
        check("pre_rst_stall", obs_stall, 1);
        step(1, 5, 0, 1, 0, 6, 1, 0, 0, 1);
        check("rst_mid_stall", obs_stall, 0);
        check("rst_mid_fwd", ex_fwd_rs, 0);
        check("rst_mid_cnt", stall_count, 0);
        step(1, 5, 0, 1, 0, 6, 1, 0, 0, 0);
        check("rst_no_fwd", ex_fwd_rs, 0);

`ifdef FWD_BRANCH_EN
        // add r2 ; beq r2
        do_reset();
        step(1, 1, 1, 1, 1, 2, 1, 0, 0, 0);
        step(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        check("br_stall", obs_stall, 1);
        id_valid = 1;
        #1;
        check("br_cmp", id_cmp_rs, 2);
        step(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        check("br_release", obs_stall, 0);
`endif

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
